// File: rtl/em_pkg.sv
// Shared sizing for the stochastic-decoder edge memory node.
package em_pkg;

  localparam int unsigned EM_S_DEF = 8;

  // Smallest address width that covers every entry of a depth-'depth' memory.
  function automatic int unsigned sel_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 7; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

  localparam int unsigned SEL_W_DEF = sel_width(EM_S_DEF);

endpackage

// File: rtl/edge_memory_node_sel_mux.sv
// Generic combinational NR:1 single-bit selector.
module sel_mux #(
  parameter int unsigned NR = 2,
  parameter int unsigned NS = 1
) (
  input  logic [NR-1:0] in_i,
  input  logic [NS-1:0] sel_i,
  output logic          out_o
);

  always_comb begin
    out_o = 1'b0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (sel_i == NS'(i)) out_o = in_i[i];
    end
  end

endmodule

// File: rtl/edge_memory_node.sv
// Stochastic equality node: forwards agreeing bits into a shift-register edge
// memory, otherwise replays a randomly addressed past bit.
module edge_memory_node
  import em_pkg::*;
#(
  parameter int unsigned EM_S  = EM_S_DEF,
  parameter int unsigned SEL_W = sel_width(EM_S)
) (
  input  logic             CLK_D2S,
  input  logic             RST,
  input  logic             INIT,
  input  logic [1:0]       R,
  input  logic             c,
  input  logic [SEL_W-1:0] EM_SEL,
  output logic             Q,
  output logic             EM_FLAG
);

  logic            temp_a;
  logic            temp_b;
  logic            u;
  logic            we;
  logic            em_in;
  logic            em_out;
  logic            q_d;
  logic            q_q;
  logic            flag_d;
  logic            flag_q;
  logic [EM_S-1:0] mem_d;
  logic [EM_S-1:0] mem_q;

  assign temp_a = R[0] & R[1] & c;
  assign temp_b = ~R[0] & ~R[1] & ~c;
  assign u      = temp_a | temp_b;
  assign we     = INIT | u;

  // Read uses pre-shift contents, so a same-cycle write never affects it.
  assign em_out = mem_q[EM_SEL];

  sel_mux #(
    .NR(2),
    .NS(1)
  ) u_mux_in (
    .in_i  ({c, temp_a}),
    .sel_i (INIT),
    .out_o (em_in)
  );

  sel_mux #(
    .NR(2),
    .NS(1)
  ) u_mux_out (
    .in_i  ({em_in, em_out}),
    .sel_i (we),
    .out_o (q_d)
  );

  always_comb begin
    mem_d  = mem_q;
    flag_d = flag_q;
    if (we) begin
      mem_d  = {mem_q[EM_S-2:0], em_in};
      flag_d = ~flag_q;
    end
  end

  always_ff @(posedge CLK_D2S or posedge RST) begin
    if (RST) begin
      mem_q  <= '0;
      q_q    <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      q_q    <= q_d;
      flag_q <= flag_d;
    end
  end

  assign Q       = q_q;
  assign EM_FLAG = flag_q;

endmodule

// File: tb/tb_edge_memory_node.sv
// Scoreboard bench for edge_memory_node against a queue-based reference model.
module tb_edge_memory_node;

  localparam int unsigned DEPTH = 8;

  logic       CLK_D2S = 1'b0;
  logic       RST     = 1'b1;
  logic       INIT    = 1'b0;
  logic [1:0] R       = 2'b00;
  logic       c       = 1'b0;
  logic [2:0] EM_SEL  = 3'd0;
  logic       Q;
  logic       EM_FLAG;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  bit [1:0] exp_q[$];
  bit       model_mem[$];
  bit       model_q;
  bit       model_flag;

  edge_memory_node #(
    .EM_S (DEPTH),
    .SEL_W(3)
  ) dut (
    .CLK_D2S(CLK_D2S),
    .RST    (RST),
    .INIT   (INIT),
    .R      (R),
    .c      (c),
    .EM_SEL (EM_SEL),
    .Q      (Q),
    .EM_FLAG(EM_FLAG)
  );

  always #5 CLK_D2S = ~CLK_D2S;

  function automatic void model_reset();
    model_mem.delete();
    for (int i = 0; i < DEPTH; i++) model_mem.push_back(1'b0);
    model_q    = 1'b0;
    model_flag = 1'b0;
  endfunction

  // Any write stores c: under INIT by definition, otherwise agreement means all bits equal c.
  function automatic void model_eval(bit init, bit [1:0] r, bit cc, int sel);
    bit agree;
    agree = (r[0] == r[1]) && (r[0] == cc);
    if (init || agree) begin
      model_q = cc;
      model_mem.push_front(cc);
      void'(model_mem.pop_back());
      model_flag = ~model_flag;
    end else begin
      model_q = model_mem[sel];
    end
  endfunction

  task automatic step(input bit rst, input bit init, input bit [1:0] r,
                      input bit cc, input bit [2:0] sel);
    @(negedge CLK_D2S);
    RST = rst; INIT = init; R = r; c = cc; EM_SEL = sel;
    @(posedge CLK_D2S);
    if (rst) model_reset();
    else     model_eval(init, r, cc, int'(sel));
    exp_q.push_back({model_q, model_flag});
  endtask

  always @(posedge CLK_D2S) begin
    bit [1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (Q !== e[1]) begin
        miscompares++;
        $display("FAIL Q at %0t: got %b expected %b", $time, Q, e[1]);
      end
      vectors++;
      if (EM_FLAG !== e[0]) begin
        miscompares++;
        $display("FAIL EM_FLAG at %0t: got %b expected %b", $time, EM_FLAG, e[0]);
      end
    end
  end

  initial begin
    bit [7:0] init_seq;
    model_reset();
    init_seq = 8'b1011_0010;

    step(1'b1, 1'b0, 2'b00, 1'b0, 3'd0);
    step(1'b1, 1'b0, 2'b00, 1'b0, 3'd0);

    // Init load: c = 1,0,1,1,0,0,1,0
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, 2'b00, init_seq[i], 3'd0);
    // Hold reads expose mem[0..7] = 0,1,0,0,1,1,0,1
    for (int s = 0; s < 8; s++) step(1'b0, 1'b0, 2'b10, 1'b1, 3'(s));

    step(1'b0, 1'b0, 2'b11, 1'b1, 3'd3);
    step(1'b0, 1'b0, 2'b00, 1'b0, 3'd0);
    for (int s = 0; s < 8; s++) step(1'b0, 1'b0, 2'b10, 1'b1, 3'(s));
    step(1'b0, 1'b1, 2'b11, 1'b0, 3'd7);
    step(1'b0, 1'b0, 2'b01, 1'b0, 3'd0);

    for (int n = 0; n < 300; n++)
      step(1'b0, ($urandom_range(7) == 0), 2'($urandom), 1'($urandom), 3'($urandom));

    // Ensure nonzero state, then reset asynchronously away from an edge.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 1'b1, 3'd0);
    step(1'b0, 1'b0, 2'b11, 1'b1, 3'd0);
    @(negedge CLK_D2S);
    #2 RST = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (Q !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_Q: got %b expected 0", Q);
    end
    vectors++;
    if (EM_FLAG !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_EM_FLAG: got %b expected 0", EM_FLAG);
    end
    step(1'b1, 1'b0, 2'b00, 1'b0, 3'd0);
    step(1'b0, 1'b0, 2'b01, 1'b1, 3'd5);

    // Reset during INIT, then more random traffic.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 1'b1, 3'd0);
    step(1'b1, 1'b1, 2'b00, 1'b1, 3'd0);
    for (int s = 0; s < 8; s++) step(1'b0, 1'b0, 2'b01, 1'b0, 3'(s));
    for (int n = 0; n < 300; n++)
      step(1'b0, ($urandom_range(5) == 0), 2'($urandom), 1'($urandom), 3'($urandom));

    @(negedge CLK_D2S);
    @(negedge CLK_D2S);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edge_memory_node.md
# edge_memory_node

Synchronous equality node with an EM_S-deep edge memory, used inside stochastic decoder equality nodes. Each cycle it evaluates whether the two parity-check inputs and the channel bit agree. On agreement it forwards that bit and pushes it into the edge memory. Otherwise it outputs a randomly addressed past edge-memory bit. During INIT it preloads the edge memory from the channel stream.

## Interface
- EM_S, default 8: edge memory depth in bits. Power of two, 2..64.
- SEL_W, default 3: log2(EM_S); width of the random address.
- CLK_D2S  in  1: clock. All state changes on the rising edge.
- RST  in  1: reset, asynchronous, active-high.
- INIT  in  1: initialization mode. The edge memory loads c every cycle.
- R  in  2: stochastic bits from the two parity-check nodes.
- c  in  1: stochastic channel-probability bit.
- EM_SEL  in  SEL_W: random read address, driven by an external LFSR.
- Q  out  1: registered output bit to the parity-check nodes.
- EM_FLAG  out  1: toggles on every edge-memory write. Debug and coverage use.

## Operation
- Agreement term tempA = R[0] & R[1] & c.
- Agreement term tempB = ~R[0] & ~R[1] & ~c.
- Regenerative indicator U = tempA | tempB. U=1 is non-hold; U=0 is hold.
- Edge-memory input, selected by mux instance 0:
  - EM_IN = c when INIT=1.
  - EM_IN = tempA when INIT=0.
- Edge-memory read: EM_OUT = mem[EM_SEL], combinational.
  - Every EM_SEL value addresses a valid entry.
  - EM_SEL has no wrap or clamp logic.
- Output selection, mux instance 1:
  - Q_next = EM_IN when (U | INIT) = 1.
  - Q_next = EM_OUT otherwise.
- Write enable: WE = INIT | U.
- Write action when WE=1, as a shift register:
  - mem[0] <= EM_IN.
  - mem[i] <= mem[i-1] for i = 1..EM_S-1.
  - mem[EM_S-1] is discarded.
  - EM_FLAG <= ~EM_FLAG.
- When WE=0, mem and EM_FLAG hold.
- Read and write in the same cycle: EM_OUT uses the pre-shift contents.
- INIT=1 overrides U. Q follows c and mem fills with c regardless of R.

## Timing
- Q is registered: Q(t+1) = Q_next(t). Latency from R/c/EM_SEL to Q is 1 cycle.
- Written data is readable one cycle after the write edge.
- RST asserted, at any time including mid-INIT, immediately forces:
  - mem = all 0,
  - Q = 0,
  - EM_FLAG = 0.
- First edge after RST deasserts performs normal evaluation.
- Reset values: Q=0, EM_FLAG=0.
- No handshake. Every input is sampled on every rising edge.
- INIT dropping to 0 takes effect on the next edge with no flush. mem retains its contents.

## Structure
- Sub-module sel_mux:
  - Parameters NR (number of inputs) and NS (select width).
  - Pure combinational N:1 selector.
  - Instantiated twice, both with NR=2, NS=1.
- Edge memory and output register sit inline in edge_memory_node, not in a separate sub-module.
- Shared package em_pkg holds:
  - EM_S default,
  - SEL_W default,
  - the function or constant that derives SEL_W from EM_S.

## Test plan
- Reset:
  - Assert RST mid-run.
  - Required: Q=0 and EM_FLAG=0 immediately.
  - After release with INIT=0, R=2'b01, c=1, EM_SEL=5: Q=0 one cycle later, because mem[5] is 0.
- Init load:
  - INIT=1, c sequence 1,0,1,1,0,0,1,0 over 8 cycles.
  - Required: mem[0..7] = 0,1,0,0,1,1,0,1, with mem[0] holding the newest bit.
  - Q mirrors c delayed 1 cycle.
  - EM_FLAG toggles 8 times and ends at 0.
- Regenerative 1:
  - After init, INIT=0, R=2'b11, c=1.
  - Required: Q=1 next cycle, 1 shifted into mem[0], EM_FLAG toggles.
- Regenerative 0:
  - R=2'b00, c=0.
  - Required: Q=0, 0 shifted in, EM_FLAG toggles.
- Hold state:
  - R=2'b10, c=1. Step EM_SEL through 0..7.
  - Required: Q equals mem[EM_SEL] each following cycle.
  - No shift and no EM_FLAG toggle.
- INIT priority:
  - INIT=1, R=2'b11, c=0.
  - Required: Q=0 and 0 written. INIT overrides agreement.
